// File: rtl/l2_pool_buf.sv
// Two conv line buffers snapshotted on pool start; streams NCOL/2 signed 2x2 (or 1x2) max results.
// Latency: first result valid right after the start edge; one per handshake; data/last hold while out_ready_i=0.
module l2_pool_buf #(
   parameter int DW   = 8,
   parameter int NCOL = 12
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic signed [DW-1:0] conv_data_i,
   input  logic [3:0]           line_sel_i,
   input  logic                 line0_we_i,
   input  logic                 line1_we_i,
   input  logic                 pool_start_i,
   input  logic                 single_line_i,
   output logic                 out_valid_o,
   output logic signed [DW-1:0] out_data_o,
   output logic                 out_last_o,
   input  logic                 out_ready_i,
   output logic                 busy_o,
   output logic                 overrun_o
);

   localparam int NPAIR = NCOL / 2;
   localparam int PW = (NPAIR > 1) ? $clog2(NPAIR) : 1;
   localparam logic [PW-1:0] LASTIDX = PW'(NPAIR - 1);
   localparam logic [3:0] NCOLSEL = 4'(NCOL);

   typedef enum logic {IDLE, POOL} state_t;

   state_t              state, stateNext;
   logic [PW-1:0]       pidx, pidxNext;
   logic                sl;
   logic                overrunQ, overrunNext;
   logic                startAcc;
   logic [PW:0]         colEven, colOdd;
   logic signed [DW-1:0] m0, m1;

   logic signed [DW-1:0] line0   [NCOL];
   logic signed [DW-1:0] line1   [NCOL];
   logic signed [DW-1:0] shadow0 [NCOL];
   logic signed [DW-1:0] shadow1 [NCOL];

   function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                 input logic signed [DW-1:0] b);
      return (a > b) ? a : b;
   endfunction

   // Live buffers accept writes regardless of pooling state; out-of-range columns are dropped.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NCOL; i++) begin
            line0[i] <= '0;
            line1[i] <= '0;
         end
      end else begin
         if (line0_we_i && (line_sel_i < NCOLSEL)) line0[line_sel_i] <= conv_data_i;
         if (line1_we_i && (line_sel_i < NCOLSEL)) line1[line_sel_i] <= conv_data_i;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NCOL; i++) begin
            shadow0[i] <= '0;
            shadow1[i] <= '0;
         end
         sl <= 1'b0;
      end else if (startAcc) begin
         for (int i = 0; i < NCOL; i++) begin
            shadow0[i] <= line0[i];
            shadow1[i] <= line1[i];
         end
         sl <= single_line_i;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         pidx     <= '0;
         overrunQ <= 1'b0;
      end else begin
         state    <= stateNext;
         pidx     <= pidxNext;
         overrunQ <= overrunNext;
      end
   end

   always_comb begin
      stateNext   = state;
      pidxNext    = pidx;
      startAcc    = 1'b0;
      overrunNext = 1'b0;
      case (state)
         IDLE: begin
            if (pool_start_i) begin
               startAcc  = 1'b1;
               pidxNext  = '0;
               stateNext = POOL;
            end
         end
         POOL: begin
            // A start during pooling, even on the final beat, is flagged and dropped.
            overrunNext = pool_start_i;
            if (out_ready_i) begin
               if (pidx == LASTIDX) stateNext = IDLE;
               else                 pidxNext  = pidx + PW'(1);
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      colEven    = {pidx, 1'b0};
      colOdd     = {pidx, 1'b1};
      m0         = smax(shadow0[colEven], shadow0[colOdd]);
      m1         = smax(shadow1[colEven], shadow1[colOdd]);
      out_data_o = sl ? m0 : smax(m0, m1);
   end

   assign out_valid_o = (state == POOL);
   assign busy_o      = (state == POOL);
   assign out_last_o  = (state == POOL) && (pidx == LASTIDX);
   assign overrun_o   = overrunQ;

endmodule
